// File: rtl/axi_wb_pkg.sv
// Shared types and AXI constants for the burst stream writer.
package axi_wb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_AW,
    ST_W,
    ST_B
  } wb_state_e;

  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  // AxSIZE encoding for a full-width beat of data_w bits.
  function automatic logic [2:0] axi_size(input int data_w);
    return 3'($clog2(data_w / 8));
  endfunction

endpackage

// File: rtl/axi_burst_len_calc.sv
// Beats for the next burst: min(remaining, MAX_BURST, 4 KiB room).
// The 4 KiB limit is compiled in only when AXI_BURST_4K_SPLIT_EN is defined.
module axi_burst_len_calc
  import axi_wb_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 16,
  parameter int LEN_W     = 16,
  parameter int MAX_BURST = 16
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [LEN_W-1:0]  remaining,
  output logic [8:0]        beats
);

  localparam logic [2:0] AWSIZE = axi_size(DATA_W);

  logic unused_addr;
  assign unused_addr = ^addr;

`ifdef AXI_BURST_4K_SPLIT_EN
  logic [12:0] page_room;
  assign page_room = (13'd4096 - {1'b0, addr[11:0]}) >> AWSIZE;
`endif

  // NOTE: every variable written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    beats = (32'(remaining) >= MAX_BURST) ? 9'(MAX_BURST) : 9'(remaining);
`ifdef AXI_BURST_4K_SPLIT_EN
    if (32'(page_room) < 32'(beats)) beats = 9'(page_room);
`endif
  end

endmodule

// File: rtl/axi_burst_stream_writer.sv
// Drains a ready/valid word stream into AXI4 INCR write bursts at a commanded address.
// Optional 4 KiB burst splitting: define AXI_BURST_4K_SPLIT_EN.
module axi_burst_stream_writer
  import axi_wb_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 16,
  parameter int LEN_W     = 16,
  parameter int MAX_BURST = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [LEN_W-1:0]    cmd_len,
  input  logic [DATA_W-1:0]   in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [ADDR_W-1:0]   s_axi_awaddr,
  output logic [7:0]          s_axi_awlen,
  output logic [2:0]          s_axi_awsize,
  output logic [1:0]          s_axi_awburst,
  output logic                s_axi_awvalid,
  input  logic                s_axi_awready,
  output logic [DATA_W-1:0]   s_axi_wdata,
  output logic [DATA_W/8-1:0] s_axi_wstrb,
  output logic                s_axi_wlast,
  output logic                s_axi_wvalid,
  input  logic                s_axi_wready,
  input  logic [1:0]          s_axi_bresp,
  input  logic                s_axi_bvalid,
  output logic                s_axi_bready,
  output logic                done,
  output logic                err
);

  localparam logic [2:0] AWSIZE = axi_size(DATA_W);

  wb_state_e         state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  remaining_q;
  logic [8:0]        beats_q;
  logic [8:0]        beat_cnt_q;
  logic [7:0]        awlen_q;
  logic              awvalid_q;
  logic              wlast_q;
  logic              bready_q;
  logic              err_acc_q;
  logic              done_q;
  logic              err_q;

  logic [ADDR_W-1:0] calc_addr;
  logic [LEN_W-1:0]  calc_rem;
  logic [8:0]        calc_beats;
  logic              w_hs;
  logic              resp_err;

  // The length calculator serves both the first burst (straight from the
  // command) and every follow-on burst (address advanced past the one just acked).
  always_comb begin
    calc_addr = cmd_addr;
    calc_rem  = cmd_len;
    if (state_q == ST_B) begin
      calc_addr = addr_q + (ADDR_W'(beats_q) << AWSIZE);
      calc_rem  = remaining_q;
    end
  end

  axi_burst_len_calc #(
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .LEN_W     (LEN_W),
    .MAX_BURST (MAX_BURST)
  ) u_len_calc (
    .addr      (calc_addr),
    .remaining (calc_rem),
    .beats     (calc_beats)
  );

  assign w_hs     = (state_q == ST_W) && in_valid && s_axi_wready;
  assign resp_err = (s_axi_bresp == AXI_RESP_SLVERR) || (s_axi_bresp == AXI_RESP_DECERR);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      beats_q     <= '0;
      beat_cnt_q  <= '0;
      awlen_q     <= '0;
      awvalid_q   <= 1'b0;
      wlast_q     <= 1'b0;
      bready_q    <= 1'b0;
      err_acc_q   <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (cmd_valid) begin
            err_acc_q   <= 1'b0;
            addr_q      <= cmd_addr;
            remaining_q <= cmd_len;
            if (cmd_len == '0) begin
              done_q <= 1'b1;
            end else begin
              state_q   <= ST_AW;
              awvalid_q <= 1'b1;
              awlen_q   <= 8'(calc_beats - 9'd1);
              beats_q   <= calc_beats;
            end
          end
        end
        ST_AW: begin
          if (s_axi_awready) begin
            awvalid_q  <= 1'b0;
            state_q    <= ST_W;
            beat_cnt_q <= beats_q;
            wlast_q    <= (beats_q == 9'd1);
          end
        end
        ST_W: begin
          if (w_hs) begin
            beat_cnt_q  <= beat_cnt_q - 9'd1;
            remaining_q <= remaining_q - LEN_W'(1);
            if (wlast_q) begin
              wlast_q  <= 1'b0;
              bready_q <= 1'b1;
              state_q  <= ST_B;
            end else begin
              wlast_q <= (beat_cnt_q == 9'd2);
            end
          end
        end
        ST_B: begin
          if (s_axi_bvalid) begin
            bready_q  <= 1'b0;
            err_acc_q <= err_acc_q | resp_err;
            if (remaining_q != '0) begin
              state_q   <= ST_AW;
              addr_q    <= calc_addr;
              awvalid_q <= 1'b1;
              awlen_q   <= 8'(calc_beats - 9'd1);
              beats_q   <= calc_beats;
            end else begin
              state_q <= ST_IDLE;
              done_q  <= 1'b1;
              err_q   <= err_acc_q | resp_err;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready     = (state_q == ST_IDLE) && !rst;
  assign in_ready      = (state_q == ST_W) && s_axi_wready;
  assign s_axi_awaddr  = addr_q;
  assign s_axi_awlen   = awlen_q;
  assign s_axi_awsize  = AWSIZE;
  assign s_axi_awburst = AXI_BURST_INCR;
  assign s_axi_awvalid = awvalid_q;
  assign s_axi_wdata   = in_data;
  assign s_axi_wstrb   = '1;
  assign s_axi_wlast   = wlast_q;
  assign s_axi_wvalid  = (state_q == ST_W) && in_valid;
  assign s_axi_bready  = bready_q;
  assign done          = done_q;
  assign err           = err_q;

endmodule
